fifo_ms_join: RTL and testbench

Two-producer, single-consumer token FIFO for the dataflow network. It sits directly downstream of actors such as the 1-port/2-flow SDF actor and collects the `wr`/`out_data` tokens of up to two producers into one ordered stream. The stream feeds a downstream actor through the standard `empty`/`rd`/`dataout` side. It is the merge counterpart of the multi-output broadcast FIFO.

---
 rtl/fifo_ms_join.sv | 110 +++++++++++
 tb/tb_fifo_ms_join.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ms_join.sv
// fifo_ms_join: two-producer, single-consumer token FIFO.
// Producer 0 and producer 1 tokens are merged into one ordered stream; when
// both write on the same edge, producer 0's token is stored ahead of
// producer 1's. The full flags reserve room for a dual write, so the two
// producers never need arbitration.
// Optional feature: define FIFO_MS_JOIN_LEVEL_EN to add the `level`
// (occupancy) and `ovf` (sticky dropped-write) output ports.
module fifo_ms_join #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       wr0,
    input  logic [WIDTH-1:0]           datain0,
    output logic                       full0,
    input  logic                       wr1,
    input  logic [WIDTH-1:0]           datain1,
    output logic                       full1,
    input  logic                       rd,
    output logic                       empty,
`ifdef FIFO_MS_JOIN_LEVEL_EN
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
`endif
    output logic [WIDTH-1:0]           dataout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          a0, a1, ar;
    logic          full;
    logic [AW-1:0] wp_next1;

    // Flag decode from the registered count; full leaves headroom for two writes.
    always_comb begin
        full    = (cnt_q > CW'(DEPTH - 2));
        empty   = (cnt_q == '0);
        full0   = full;
        full1   = full;
        dataout = mem[rp_q];
    end

    // Accepted operations and next pointer/count values.
    always_comb begin
        a0       = wr0 & ~full;
        a1       = wr1 & ~full;
        ar       = rd & ~empty;
        wp_next1 = wp_q + AW'(1);
        wp_d     = wp_q + AW'(a0) + AW'(a1);
        rp_d     = rp_q + AW'(ar);
        cnt_d    = cnt_q + CW'(a0) + CW'(a1) - CW'(ar);
    end

    // Pointer and occupancy registers, cleared by asynchronous reset.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Token storage (not reset); producer 1 lands after producer 0 on a dual write.
    always_ff @(posedge ck) begin
        if (a0) begin
            mem[wp_q] <= datain0;
        end
        if (a1) begin
            if (a0) begin
                mem[wp_next1] <= datain1;
            end else begin
                mem[wp_q] <= datain1;
            end
        end
    end

`ifdef FIFO_MS_JOIN_LEVEL_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: any write strobe presented while its port is full.
    always_comb begin
        ovf_d = ovf_q | (wr0 & full) | (wr1 & full);
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign level = cnt_q;
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_ms_join.sv
// Scoreboard bench for fifo_ms_join (WIDTH=8, DEPTH=4).
module tb_fifo_ms_join;

    localparam int DEPTH = 4;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       wr0 = 1'b0, wr1 = 1'b0, rd = 1'b0;
    logic [7:0] datain0 = '0, datain1 = '0;
    logic       full0, full1, empty;
    logic [7:0] dataout;
`ifdef FIFO_MS_JOIN_LEVEL_EN
    logic [2:0] level;
    logic       ovf;
`endif

    fifo_ms_join #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .ck(ck), .rst(rst),
        .wr0(wr0), .datain0(datain0), .full0(full0),
        .wr1(wr1), .datain1(datain1), .full1(full1),
        .rd(rd), .empty(empty),
`ifdef FIFO_MS_JOIN_LEVEL_EN
        .level(level), .ovf(ovf),
`endif
        .dataout(dataout)
    );

    always #5 ck = ~ck;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    int         mcnt = 0;
    logic       movf = 1'b0;
    int         stalls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the consumer pops a non-empty FIFO, compare with the scoreboard head.
    always @(negedge ck) begin
        if (rst && rd && !empty) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_token actual=%0h expected=none at %0t", dataout, $time);
            end else begin
                check("read_data", {24'd0, dataout}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_full0"}, {31'd0, full0}, {31'd0, (mcnt > DEPTH - 2)});
        check({tag, "_full1"}, {31'd0, full1}, {31'd0, (mcnt > DEPTH - 2)});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, (mcnt == 0)});
`ifdef FIFO_MS_JOIN_LEVEL_EN
        check({tag, "_level"}, {29'd0, level}, mcnt);
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, movf});
`endif
    endtask

    // One clock cycle of stimulus; expected tokens are pushed on issue.
    task automatic cyc(input logic w0, input logic [7:0] d0, input logic w1,
                       input logic [7:0] d1, input logic r);
        bit fullm, a0, a1, ar;
        check_flags("pre");
        fullm = (mcnt > DEPTH - 2);
        a0 = w0 && !fullm;
        a1 = w1 && !fullm;
        ar = r && (mcnt != 0);
        if ((w0 || w1) && fullm) movf = 1'b1;
        if (a0) sb.push_back(d0);
        if (a1) sb.push_back(d1);
        mcnt = mcnt + int'(a0) + int'(a1) - int'(ar);
        wr0 = w0; datain0 = d0; wr1 = w1; datain1 = d1; rd = r;
        @(posedge ck);
        #1;
        wr0 = 1'b0; wr1 = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check_flags("reset");
        @(posedge ck); #1;
        rst = 1'b1;
        @(posedge ck); #1;

        // Three port-0 writes, head shows the first one
        cyc(1'b1, 8'd1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'd2, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'd3, 1'b0, 8'h00, 1'b0);
        check("fill_full0", {31'd0, full0}, 32'd1);
        check("fill_head", {24'd0, dataout}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("drain_empty", {31'd0, empty}, 32'd1);

        // Dual write into an empty FIFO, producer 0 first
        cyc(1'b1, 8'hA0, 1'b1, 8'hB1, 1'b0);
        check("dual_head", {24'd0, dataout}, 32'h0A0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("dual_empty", {31'd0, empty}, 32'd1);

        // Steady read+write at cnt=2 across pointer wrap
        cyc(1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h21, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h11 + i), 1'b0, 8'h00, 1'b1);
        check("wrap_head", {24'd0, dataout}, 32'h019);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Read while empty is ignored
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
        check("after_empty_rd_head", {24'd0, dataout}, 32'h03C);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // cnt 2 -> dual write -> 4, then a dropped port-1 write
        cyc(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
        cyc(1'b1, 8'h42, 1'b1, 8'h43, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 8'hFE, 1'b0, 8'h00, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        idle(1);

        // Single read from cnt=3 clears full
        cyc(1'b1, 8'h60, 1'b1, 8'h61, 1'b0);
        cyc(1'b1, 8'h62, 1'b0, 8'h00, 1'b0);
        check("cnt3_full", {31'd0, full0}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("cnt2_notfull", {31'd0, full1}, 32'd0);

        // Refill to 3, then asynchronous reset between edges
        cyc(1'b1, 8'h63, 1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_empty", {31'd0, empty}, 32'd1);
        check("async_full0", {31'd0, full0}, 32'd0);
        check("async_full1", {31'd0, full1}, 32'd0);
        sb.delete();
        mcnt = 0;
        movf = 1'b0;
        @(posedge ck); #3;
        rst = 1'b1;
        @(posedge ck); #1;
        check_flags("post_reset");
        cyc(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
        check("post_reset_head", {24'd0, dataout}, 32'h05A);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Upstream actor emits 0..3 on port 0 while the consumer reads every cycle
        for (int i = 0; i < 4; i++) begin
            if (full0) stalls++;
            cyc(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("actor_stalls", stalls, 32'd0);

        idle(2);
        check("sb_drained", sb.size(), 32'd0);
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
